// File: rtl/rv32_pkg.sv
// Shared RV32I front-end definitions: opcodes, op_class codes, decoded bundle and FSM states.
// Imported by the fetch/decode stage and its combinational decoder.
package rv32_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

    typedef enum logic [3:0] {
        CLS_LUI    = 4'd0,
        CLS_AUIPC  = 4'd1,
        CLS_JAL    = 4'd2,
        CLS_JALR   = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_LOAD   = 4'd5,
        CLS_STORE  = 4'd6,
        CLS_OP_IMM = 4'd7,
        CLS_OP     = 4'd8,
        CLS_SYSTEM = 4'd9,
        CLS_NONE   = 4'd15
    } op_class_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fd_state_t;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        op_class_t   op_class;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/rv32_decoder.sv
// Combinational RV32I decode of an instruction word into register indices, immediate and class.
// Zero latency; no handshake.
module rv32_decoder
    import rv32_pkg::*;
(
    input  logic [31:0] i_ir,
    output dec_t        o_dec
);

    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_imm_i = {{20{i_ir[31]}}, i_ir[31:20]};
    assign w_imm_s = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
    assign w_imm_b = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
    assign w_imm_u = {i_ir[31:12], 12'b0};
    assign w_imm_j = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};

    always_comb begin
        o_dec          = '0;
        o_dec.rs1      = i_ir[19:15];
        o_dec.rs2      = i_ir[24:20];
        o_dec.rd       = i_ir[11:7];
        o_dec.funct3   = i_ir[14:12];
        o_dec.funct7b5 = i_ir[30];
        o_dec.op_class = CLS_NONE;
        o_dec.illegal  = 1'b0;
        case (i_ir[6:0])
            OPC_LUI, OPC_AUIPC: begin
                o_dec.op_class = (i_ir[6:0] == OPC_LUI) ? CLS_LUI : CLS_AUIPC;
                o_dec.rs1      = 5'd0;
                o_dec.rs2      = 5'd0;
                o_dec.imm      = w_imm_u;
            end
            OPC_JAL: begin
                o_dec.op_class = CLS_JAL;
                o_dec.rs1      = 5'd0;
                o_dec.rs2      = 5'd0;
                o_dec.imm      = w_imm_j;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: begin
                case (i_ir[6:0])
                    OPC_JALR:   o_dec.op_class = CLS_JALR;
                    OPC_LOAD:   o_dec.op_class = CLS_LOAD;
                    OPC_OP_IMM: o_dec.op_class = CLS_OP_IMM;
                    default:    o_dec.op_class = CLS_SYSTEM;
                endcase
                o_dec.rs2 = 5'd0;
                o_dec.imm = w_imm_i;
            end
            OPC_BRANCH: begin
                o_dec.op_class = CLS_BRANCH;
                o_dec.rd       = 5'd0;
                o_dec.imm      = w_imm_b;
            end
            OPC_STORE: begin
                o_dec.op_class = CLS_STORE;
                o_dec.rd       = 5'd0;
                o_dec.imm      = w_imm_s;
            end
            OPC_OP: begin
                o_dec.op_class = CLS_OP;
            end
            default: begin
                o_dec.illegal = 1'b1;
            end
        endcase
        // Compressed-space words (low bits != 11) never match a listed opcode, so they land here too.
        if (o_dec.illegal) begin
            o_dec.rs1 = 5'd0;
            o_dec.rs2 = 5'd0;
            o_dec.rd  = 5'd0;
            o_dec.imm = '0;
        end
    end

endmodule

// File: rtl/fetch_decode.sv
// RV32I front end: owns the PC, fetches over imem req/ack, issues the decoded IR under valid/ready.
// Fetch-to-issue is 3 cycles minimum; the bundle holds until dec_ready, redirects override everything.
module fetch_decode
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        stage_clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] pc,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic [3:0]  op_class,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic        illegal
);

    fd_state_t   r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_ir, w_ir_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic        r_req, w_req_nxt;
    logic        r_flush, w_flush_nxt;
    logic [31:0] w_redir_pc;
    dec_t        w_dec;

    assign w_redir_pc = redirect_pc & ~32'h3;

    rv32_decoder u_dec (
        .i_ir  (r_ir),
        .o_dec (w_dec)
    );

    always_ff @(posedge stage_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= NOP_INSTR;
            r_addr  <= RESET_PC;
            r_req   <= 1'b0;
            r_flush <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_addr  <= w_addr_nxt;
            r_req   <= w_req_nxt;
            r_flush <= w_flush_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_addr_nxt  = r_addr;
        w_req_nxt   = r_req;
        w_flush_nxt = r_flush;
        case (r_state)
            ST_FETCH: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redir_pc;
                end else begin
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = r_pc;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    w_req_nxt   = 1'b0;
                    w_flush_nxt = 1'b0;
                    if (redirect_valid) begin
                        w_pc_nxt    = w_redir_pc;
                        w_state_nxt = ST_FETCH;
                    end else if (r_flush) begin
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_ir_nxt    = imem_rdata;
                        w_state_nxt = ST_ISSUE;
                    end
                end else if (redirect_valid) begin
                    // The outstanding request must still complete; its word is dropped on ack.
                    w_pc_nxt    = w_redir_pc;
                    w_flush_nxt = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = ST_FETCH;
                end else if (dec_ready) begin
                    w_pc_nxt    = r_pc + PC_STEP;
                    w_state_nxt = w_dec.illegal ? ST_HALT : ST_FETCH;
                end
            end
            default: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = ST_FETCH;
                end
            end
        endcase
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign dec_valid = (r_state == ST_ISSUE);
    assign pc        = r_pc;
    assign rs1       = w_dec.rs1;
    assign rs2       = w_dec.rs2;
    assign rd        = w_dec.rd;
    assign imm       = w_dec.imm;
    assign op_class  = w_dec.op_class;
    assign funct3    = w_dec.funct3;
    assign funct7b5  = w_dec.funct7b5;
    assign illegal   = w_dec.illegal;

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: directed test-plan sequences followed by randomized traffic,
// all checked every cycle against a transaction-level model of the stage.
module tb_fetch_decode;
    import rv32_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int P_NEED  = 0;
    localparam int P_REQ   = 1;
    localparam int P_VALID = 2;
    localparam int P_HALT  = 3;

    logic        stage_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  op_class;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        illegal;

    fetch_decode #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
        .stage_clk(stage_clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .pc(pc),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .op_class(op_class),
        .funct3(funct3), .funct7b5(funct7b5), .illegal(illegal)
    );

    always #5 stage_clk = ~stage_clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  cls;
        logic        ill;
    } ref_t;

    function automatic logic [31:0] sext(input logic [31:0] v, input int n);
        logic [31:0] m;
        m = 32'd1 << (n - 1);
        return (v ^ m) - m;
    endfunction

    // Reference decode from the ISA format table.
    function automatic ref_t ref_decode(input logic [31:0] w);
        ref_t r;
        logic [7:0] fmt;
        r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7];
        r.imm = '0; r.cls = 4'hF; r.ill = 1'b0;
        fmt = "X";
        case (w[6:0])
            7'b0110111: begin fmt = "U"; r.cls = CLS_LUI;    end
            7'b0010111: begin fmt = "U"; r.cls = CLS_AUIPC;  end
            7'b1101111: begin fmt = "J"; r.cls = CLS_JAL;    end
            7'b1100111: begin fmt = "I"; r.cls = CLS_JALR;   end
            7'b1100011: begin fmt = "B"; r.cls = CLS_BRANCH; end
            7'b0000011: begin fmt = "I"; r.cls = CLS_LOAD;   end
            7'b0100011: begin fmt = "S"; r.cls = CLS_STORE;  end
            7'b0010011: begin fmt = "I"; r.cls = CLS_OP_IMM; end
            7'b0110011: begin fmt = "R"; r.cls = CLS_OP;     end
            7'b1110011: begin fmt = "I"; r.cls = CLS_SYSTEM; end
            default:    fmt = "X";
        endcase
        if (w[1:0] != 2'b11) fmt = "X";
        case (fmt)
            "U": begin r.rs1 = 0; r.rs2 = 0; r.imm = w & 32'hFFFF_F000; end
            "J": begin r.rs1 = 0; r.rs2 = 0;
                       r.imm = sext(32'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21); end
            "I": begin r.rs2 = 0; r.imm = sext(32'(w[31:20]), 12); end
            "S": begin r.rd = 0; r.imm = sext(32'({w[31:25], w[11:7]}), 12); end
            "B": begin r.rd = 0;
                       r.imm = sext(32'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13); end
            "R": ;
            default: begin r.ill = 1'b1; r.rs1 = 0; r.rs2 = 0; r.rd = 0; end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                  7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};
        logic [31:0] w;
        w = $urandom();
        if ($urandom_range(0, 15) == 0) return w;
        return {w[31:7], ops[$urandom_range(0, 9)]};
    endfunction

    // Transaction-level model: where the PC must be and what the pending bundle must decode to.
    int          m_phase = P_NEED;
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_ir = NOP_INSTR;
    logic [31:0] a_addr = '0;
    logic        taint = 1'b0;
    int          need_cnt = 0;

    always @(negedge stage_clk) begin
        ref_t e;
        if (!reset_n) begin
            m_phase = P_NEED; m_pc = RST_PC; need_cnt = 0; taint = 1'b0;
        end else if (m_phase == P_HALT) begin
            check("halt_valid", 32'(dec_valid), 0);
            check("halt_req", 32'(imem_req), 0);
            if (redirect_valid) begin m_pc = redirect_pc & ~32'h3; m_phase = P_NEED; need_cnt = 0; end
        end else if (m_phase == P_VALID) begin
            e = ref_decode(m_ir);
            check("issue_valid", 32'(dec_valid), 1);
            check("issue_req", 32'(imem_req), 0);
            check("issue_pc", pc, m_pc);
            check("issue_rs1", 32'(rs1), 32'(e.rs1));
            check("issue_rs2", 32'(rs2), 32'(e.rs2));
            check("issue_rd", 32'(rd), 32'(e.rd));
            check("issue_funct3", 32'(funct3), 32'(m_ir[14:12]));
            check("issue_funct7b5", 32'(funct7b5), 32'(m_ir[30]));
            check("issue_illegal", 32'(illegal), 32'(e.ill));
            if (!e.ill) begin
                check("issue_imm", imm, e.imm);
                check("issue_class", 32'(op_class), 32'(e.cls));
            end
            if (redirect_valid) begin
                m_pc = redirect_pc & ~32'h3; m_phase = P_NEED; need_cnt = 0;
            end else if (dec_ready) begin
                if (e.ill) m_phase = P_HALT;
                else begin m_pc = m_pc + 32'd4; m_phase = P_NEED; need_cnt = 0; end
            end
        end else begin
            if (m_phase == P_NEED) begin
                check("idle_valid", 32'(dec_valid), 0);
                if (imem_req) begin
                    check("fetch_addr", imem_addr, m_pc);
                    a_addr = m_pc; taint = 1'b0; m_phase = P_REQ;
                end else begin
                    need_cnt++;
                    if (need_cnt > 1) check("fetch_start", 32'(imem_req), 1);
                    if (redirect_valid) begin m_pc = redirect_pc & ~32'h3; need_cnt = 0; end
                end
            end
            if (m_phase == P_REQ) begin
                check("req_held", 32'(imem_req), 1);
                check("addr_stable", imem_addr, a_addr);
                check("wait_valid", 32'(dec_valid), 0);
                if (imem_ack) begin
                    if (redirect_valid || taint) begin
                        if (redirect_valid) m_pc = redirect_pc & ~32'h3;
                        m_phase = P_NEED; need_cnt = 0;
                    end else begin
                        m_ir = imem_rdata; m_phase = P_VALID;
                    end
                end else if (redirect_valid) begin
                    m_pc = redirect_pc & ~32'h3; taint = 1'b1;
                end
            end
        end
    end

    // Instruction memory: acks after a programmable or random number of request cycles.
    logic [31:0] dq[$];
    int          ack_delay = 0;
    bit          rnd_mode = 1'b0;

    initial begin
        int cnt;
        cnt = -1;
        forever begin
            @(posedge stage_clk); #1;
            imem_ack = 1'b0;
            if (!reset_n || !imem_req) cnt = -1;
            else begin
                if (cnt < 0) cnt = rnd_mode ? int'($urandom_range(0, 3)) : ack_delay;
                if (cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = (dq.size() > 0) ? dq.pop_front() : (rnd_mode ? rand_instr() : NOP_INSTR);
                    cnt = -1;
                end else cnt--;
            end
        end
    end

    task automatic tick();
        @(posedge stage_clk); #1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 50 && !dec_valid; i++) tick();
        check(name, 32'(dec_valid), 1);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 50 && !imem_req; i++) tick();
        check(name, 32'(imem_req), 1);
    endtask

    task automatic handshake();
        dec_ready = 1'b1; tick(); dec_ready = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1; redirect_pc = tgt; tick(); redirect_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"}, 32'(imem_req), 0);
        check({tag, "_valid"}, 32'(dec_valid), 0);
        check({tag, "_pc"}, pc, RST_PC);
        check({tag, "_regs"}, 32'({rs1, rs2, rd}), 0);
        check({tag, "_imm"}, imm, 0);
        check({tag, "_class"}, 32'(op_class), 32'(CLS_OP_IMM));
        check({tag, "_illegal"}, 32'(illegal), 0);
    endtask

    initial begin
        int quiet;
        bit seen;
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int quiet;
        bit seen;
        tick(); tick();
        check_reset("reset");
        ack_delay = 2;
        dq.push_back(32'h0050_0093);
        reset_n = 1'b1;

        wait_valid("addi_valid");
        check("addi_rs1", 32'(rs1), 0);
        check("addi_rd", 32'(rd), 1);
        check("addi_imm", imm, 5);
        check("addi_class", 32'(op_class), 32'(CLS_OP_IMM));
        check("addi_pc", pc, 0);
        dq.push_back(32'h0020_81B3);
        ack_delay = 0;
        handshake();
        wait_req("addi_next_req");
        check("addi_next_addr", imem_addr, 32'h4);

        wait_valid("add_valid");
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (imem_req || !dec_valid) quiet++;
        end
        check("add_hold", 32'(quiet), 0);
        check("add_regs", 32'({rs1, rs2, rd, funct7b5}), 32'({5'd1, 5'd2, 5'd3, 1'b0}));
        dq.push_back(32'h0020_A423);
        handshake();

        wait_valid("sw_valid");
        check("sw_imm", imm, 8);
        check("sw_rd", 32'(rd), 0);
        check("sw_class", 32'(op_class), 32'(CLS_STORE));
        dq.push_back(32'h1234_52B7);
        handshake();

        wait_valid("lui_valid");
        check("lui_imm", imm, 32'h1234_5000);
        check("lui_rs1", 32'(rs1), 0);
        dq.push_back(32'hFE00_0EE3);
        handshake();

        wait_valid("beq_valid");
        check("beq_imm", imm, 32'hFFFF_FFFC);
        check("beq_pc", pc, 32'h10);
        dq.push_back(32'hDEAD_BEEF);
        dq.push_back(32'h0050_0093);
        ack_delay = 3;
        dec_ready = 1'b1;
        redirect(32'h103);
        dec_ready = 1'b0;
        wait_req("redir_req");
        check("redir_addr", imem_addr, 32'h100);

        redirect(32'h200);
        seen = 1'b0;
        for (int i = 0; i < 20 && imem_req; i++) begin
            tick();
            if (dec_valid) seen = 1'b1;
        end
        check("flush_no_valid", 32'(seen || dec_valid), 0);
        wait_req("flush_refetch");
        check("flush_addr", imem_addr, 32'h200);
        wait_valid("flush_valid");
        check("flush_pc", pc, 32'h200);
        check("flush_rd", 32'(rd), 1);

        dq.push_back(NOP_INSTR);
        redirect(32'hFFFF_FFFF);
        wait_req("top_req");
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid("top_valid");
        dq.push_back(32'h0000_0000);
        handshake();
        wait_req("wrap_req");
        check("wrap_addr", imem_addr, 32'h0);

        wait_valid("ill_valid");
        check("ill_flag", 32'(illegal), 1);
        check("ill_regs", 32'({rs1, rs2, rd}), 0);
        handshake();
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_req || dec_valid) quiet++;
        end
        check("halt_quiet", 32'(quiet), 0);

        ack_delay = 5;
        dq.push_back(32'h0050_0093);
        redirect(32'h40);
        wait_req("pre_reset_req");
        tick();
        #2 reset_n = 1'b0;
        #1 check_reset("midreset");
        dq.delete();
        tick(); tick();
        reset_n = 1'b1;
        ack_delay = 1;
        wait_req("restart_req");
        check("restart_addr", imem_addr, RST_PC);

        rnd_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            r = $urandom();
            dec_ready = ($urandom_range(0, 2) != 0);
            redirect_valid = (m_phase == P_HALT) || ($urandom_range(0, 24) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? {29'h1FFF_FFFF, r[2:0]} : r;
            tick();
        end
        redirect_valid = 1'b0;
        dec_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
